// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// Carries the decoded instruction fields and ALU flag into the controller,
// and carries the per-state datapath controls back out.
interface multicycle_controller_if;
  // Instruction fields and flags produced by the datapath
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  // Datapath controls produced by the controller
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic       illegal_op;

  // Controller side: consumes instruction fields, drives the controls
  modport master (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    output state, illegal_op
  );

  // Datapath side: supplies instruction fields, obeys the controls
  modport slave (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    input  state, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I subset controller (lw, sw, R-type, I-ALU, beq, jal).
// A Moore main FSM sequences each instruction through 3..5 states; the
// ALU decoder and immediate-select decoder are purely combinational.
// Write enables are gated off while reset is asserted so an abandoned
// instruction can never commit architectural state.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // True for every opcode this controller knows how to sequence.
  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL: op_supported = 1'b1;
      default:                                     op_supported = 1'b0;
    endcase
  endfunction

  // Immediate format is a function of the opcode alone, so the extender
  // is already set up for whichever state consumes ImmExt.
  function automatic logic [1:0] imm_src_dec(input logic [6:0] op);
    case (op)
      OP_LW, OP_IALU: imm_src_dec = 2'b00;
      OP_SW:          imm_src_dec = 2'b01;
      OP_BEQ:         imm_src_dec = 2'b10;
      OP_JAL:         imm_src_dec = 2'b11;
      default:        imm_src_dec = 2'b00;
    endcase
  endfunction

  // ALU operation from ALUOp and the funct fields. Subtraction needs both
  // funct7b5 and op[5]: addi with a negative immediate also has bit 30 set,
  // but op[5]=0 distinguishes it from an R-type sub.
  function automatic logic [2:0] alu_dec(input logic [1:0] alu_op,
                                         input logic [2:0] funct3,
                                         input logic       op5,
                                         input logic       funct7b5);
    case (alu_op)
      ALUOP_ADD: alu_dec = 3'b000;
      ALUOP_SUB: alu_dec = 3'b001;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_dec = (op5 && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_dec = 3'b101;
          3'b110:  alu_dec = 3'b011;
          3'b111:  alu_dec = 3'b010;
          default: alu_dec = 3'b000;
        endcase
      end
      default: alu_dec = 3'b000;
    endcase
  endfunction

  state_t     state_q, state_d;

  logic       pc_update;
  logic       branch;
  logic       adr_src;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; anything not set in a state stays 0.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        result_src = 2'b00;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        result_src    = 2'b00;
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        result_src    = 2'b00;
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_SUB;
        result_src = 2'b00;
        branch     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_update  = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch resolution, reset gating of write enables and field decoders.
  always_comb begin
    bus.PCWrite    = ~reset & (pc_update | (branch & bus.zero));
    bus.IRWrite    = ~reset & ir_write_raw;
    bus.MemWrite   = ~reset & mem_write_raw;
    bus.RegWrite   = ~reset & reg_write_raw;
    bus.AdrSrc     = adr_src;
    bus.ResultSrc  = result_src;
    bus.ALUSrcA    = alu_src_a;
    bus.ALUSrcB    = alu_src_b;
    bus.ImmSrc     = imm_src_dec(bus.op);
    bus.ALUControl = alu_dec(alu_op, bus.funct3, bus.op[5], bus.funct7b5);
    bus.state      = state_q;
    bus.illegal_op = ~reset & (state_q == S_DECODE) & ~op_supported(bus.op);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: stimulus pushes hand-computed
// expected output snapshots into a queue, a monitor pops and compares them.
module tb_multicycle_controller;

  logic clk;
  logic reset;

  multicycle_controller_if ifc ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  event  smp;

  // Hand-written expected snapshots, one per state
  function automatic exp_t e_rst(input logic [1:0] imm);
    e_rst = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_fetch(input logic [1:0] imm);
    e_fetch = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_decode(input logic [1:0] imm, input logic ill);
    e_decode = '{4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill};
  endfunction
  function automatic exp_t e_memadr(input logic [1:0] imm);
    e_memadr = '{4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_memread(input logic [1:0] imm);
    e_memread = '{4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_memwb(input logic [1:0] imm);
    e_memwb = '{4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_memwrite(input logic [1:0] imm);
    e_memwrite = '{4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_execr(input logic [2:0] alu);
    e_execr = '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0};
  endfunction
  function automatic exp_t e_execi(input logic [2:0] alu);
    e_execi = '{4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 1'b0};
  endfunction
  function automatic exp_t e_aluwb(input logic [1:0] imm);
    e_aluwb = '{4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0};
  endfunction
  function automatic exp_t e_beq(input logic pcw);
    e_beq = '{4'd9, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0};
  endfunction
  function automatic exp_t e_jal();
    e_jal = '{4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0};
  endfunction

  task automatic push(input string nm, input exp_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Queue the expectation for the current cycle, then move to the next one
  task automatic step(input string nm, input exp_t e);
    push(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    ifc.op       = o;
    ifc.funct3   = f3;
    ifc.funct7b5 = z ? f7 : f7;
    ifc.zero     = z;
  endtask

  // Monitor: compare every clock (falling edge) or on an explicit async sample
  initial begin
    exp_t  act;
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or smp);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        act = {ifc.state, ifc.PCWrite, ifc.AdrSrc, ifc.MemWrite, ifc.IRWrite,
               ifc.RegWrite, ifc.ResultSrc, ifc.ALUSrcA, ifc.ALUSrcB,
               ifc.ImmSrc, ifc.ALUControl, ifc.illegal_op};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: got %06h (state=%0d) expected %06h (state=%0d)",
                   nm, act, act.st, e, e.st);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    step("reset_state", e_rst(2'b00));
    reset = 1'b0;

    // lw: 0,1,2,3,4
    step("lw_fetch",   e_fetch(2'b00));
    step("lw_decode",  e_decode(2'b00, 1'b0));
    step("lw_memadr",  e_memadr(2'b00));
    step("lw_memread", e_memread(2'b00));
    step("lw_memwb",   e_memwb(2'b00));

    // sw: 0,1,2,5
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    step("sw_fetch",    e_fetch(2'b01));
    step("sw_decode",   e_decode(2'b01, 1'b0));
    step("sw_memadr",   e_memadr(2'b01));
    step("sw_memwrite", e_memwrite(2'b01));

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    step("sub_fetch",  e_fetch(2'b00));
    step("sub_decode", e_decode(2'b00, 1'b0));
    step("sub_exec",   e_execr(3'b001));
    step("sub_aluwb",  e_aluwb(2'b00));

    // R-type and
    set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    step("and_fetch",  e_fetch(2'b00));
    step("and_decode", e_decode(2'b00, 1'b0));
    step("and_exec",   e_execr(3'b010));
    step("and_aluwb",  e_aluwb(2'b00));

    // addi with funct7b5=1 must stay add
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    step("addi_fetch",  e_fetch(2'b00));
    step("addi_decode", e_decode(2'b00, 1'b0));
    step("addi_exec",   e_execi(3'b000));
    step("addi_aluwb",  e_aluwb(2'b00));

    // slti and ori
    set_instr(7'b0010011, 3'b010, 1'b0, 1'b0);
    step("slti_fetch",  e_fetch(2'b00));
    step("slti_decode", e_decode(2'b00, 1'b0));
    step("slti_exec",   e_execi(3'b101));
    step("slti_aluwb",  e_aluwb(2'b00));
    set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
    step("ori_fetch",  e_fetch(2'b00));
    step("ori_decode", e_decode(2'b00, 1'b0));
    step("ori_exec",   e_execi(3'b011));
    step("ori_aluwb",  e_aluwb(2'b00));

    // beq taken, then not taken
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    step("beqt_fetch",  e_fetch(2'b10));
    step("beqt_decode", e_decode(2'b10, 1'b0));
    step("beqt_beq",    e_beq(1'b1));
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    step("beqn_fetch",  e_fetch(2'b10));
    step("beqn_decode", e_decode(2'b10, 1'b0));
    step("beqn_beq",    e_beq(1'b0));

    // jal: 0,1,10,8
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    step("jal_fetch",  e_fetch(2'b11));
    step("jal_decode", e_decode(2'b11, 1'b0));
    step("jal_jal",    e_jal());
    step("jal_aluwb",  e_aluwb(2'b11));

    // unsupported opcode: illegal pulse in DECODE, back to FETCH
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    step("ill_fetch",  e_fetch(2'b00));
    step("ill_decode", e_decode(2'b00, 1'b1));

    // lw abandoned by reset in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    step("rlw_fetch",  e_fetch(2'b00));
    step("rlw_decode", e_decode(2'b00, 1'b0));
    step("rlw_memadr", e_memadr(2'b00));
    push("rlw_memread", e_memread(2'b00));
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    push("async_reset", e_rst(2'b00));
    ->smp;
    @(posedge clk);
    #1;
    step("reset_hold", e_rst(2'b00));
    reset = 1'b0;

    // first edge after reset leaves FETCH; run a full sw
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    step("post_fetch",    e_fetch(2'b01));
    step("post_decode",   e_decode(2'b01, 1'b0));
    step("post_memadr",   e_memadr(2'b01));
    step("post_memwrite", e_memwrite(2'b01));
    step("post_fetch2",   e_fetch(2'b01));

    repeat (4) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all widths and encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 op  input  7  Instr[6:0] from the instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite  output  1  PC register enable.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-010 MemWrite  output  1  data memory write enable.
REQ-011 IRWrite  output  1  instruction/OldPC register enable.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-014 ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data.
REQ-015 ALUSrcB  output  2  00=rs2 data, 01=ImmExt, 10=constant 4.
REQ-016 ImmSrc  output  2  sign-extender select: 00=I, 01=S, 10=B, 11=J.
REQ-017 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 state  output  4  current state code, for debug/VGA display.
REQ-019 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-020 The state encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-021 The supported opcodes SHALL be lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, beq=1100011, jal=1101111.
REQ-022 Transitions SHALL be: FETCH->DECODE.
- DECODE->MEMADR (lw, sw), EXECUTER (R), EXECUTEI (I-ALU), BEQ (beq), JAL (jal); any other opcode -> FETCH.
- MEMADR->MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER/EXECUTEI/JAL->ALUWB->FETCH; BEQ->FETCH.
- Encodings 11..15 SHALL return to FETCH.
REQ-023 Latency in cycles, FETCH through last state inclusive: lw 5; sw, R, I-ALU and jal 4; beq 3.
REQ-024 Unlisted outputs SHALL be 0 in every state, and the outputs SHALL be Moore per state except as noted below.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-025 PCWrite SHALL equal PCUpdate | (Branch & zero), evaluated combinationally in the same cycle.
REQ-026 ImmSrc SHALL be decoded combinationally from op in all states: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
REQ-027 ALUControl SHALL be decoded as follows.
- ALUOp 00 -> 000; ALUOp 01 -> 001.
- ALUOp 10, funct3 000: 001 if op[5]&funct7b5, else 000.
- ALUOp 10, funct3 010->101, 110->011, 111->010; other funct3 -> 000.
REQ-028 illegal_op SHALL be 1 only in a DECODE cycle whose op is unsupported.

Reset
REQ-029 reset high SHALL immediately force state=FETCH and illegal_op=0.
REQ-030 While reset is high, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-031 Asserting reset mid-instruction SHALL abandon that instruction; after reset falls, the first rising edge SHALL leave FETCH with fetch outputs active.

Verification
REQ-032 The bench SHALL cover these scenarios:
- lw (op=0000011) from reset: state sequence 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4.
- sw: sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 in state 5; ImmSrc=01 throughout.
- R-type sub (funct3=000, funct7b5=1): ALUControl=001 in EXECUTER. I-ALU addi with funct7b5=1: ALUControl=000.
- beq: zero=1 in BEQ gives PCWrite=1; zero=0 gives PCWrite=0; ImmSrc=10; next state FETCH either way.
- jal: sequence 0,1,10,8,0; PCWrite=1 in JAL; ImmSrc=11. Unsupported op=1111111: illegal_op=1 in DECODE, then FETCH.
- reset asserted in MEMREAD: state=0 and all write enables 0 immediately, with no clock edge.
